// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared encodings and default iteration counts for the
//                multiply/divide unit sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Operation encodings as presented on op_i
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Sequencer state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Default iteration counts of the MDU datapath
    localparam int unsigned MUL_CYCLES_DEF = 4;
    localparam int unsigned DIV_CYCLES_DEF = 32;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_cycle_counter.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_cycle_counter
//  Description : Loadable down-counter with zero flag that tracks the
//                remaining MDU iterations. Load has priority over decrement;
//                decrement saturates at zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_cycle_counter #(
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Remaining-iteration register: load on a new operation, count down while running
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_cnt  = r_cnt;
    assign o_zero = (r_cnt == '0);

endmodule : mdu_cycle_counter
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_ctrl
//  Description : Sequencer for the iterative multiply/divide unit. Accepts a
//                mult/div from ID/EX, steps the MDU through its fixed
//                iteration count, pulses the HI/LO write and stalls dependent
//                ID-stage instructions while the unit is busy.
//                Optional feature macro: MDU_DIV0_FAST_EN (divide-by-zero
//                finishes after one RUN cycle without writing HI/LO).
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [1:0] op_i,
    input  logic       div0_i,
    input  logic       flush_i,
    input  logic       FD_HiLoRead_i,
    input  logic       FD_MulDiv_i,
    output logic       mdu_load_o,
    output logic       mdu_step_o,
    output logic       mdu_signed_o,
    output logic       mdu_div_o,
    output logic       busy_o,
    output logic       stall_o,
    output logic       hilo_we_o,
    output logic       done_o
);

    // Counter preload values: RUN lasts LAT cycles, so the counter starts at LAT-1
    localparam logic [CNT_W-1:0] c_mul_load = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_div_load = CNT_W'(DIV_CYCLES - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [1:0]       r_op;
    logic             r_kill_ok;
    logic             w_accept;
    logic             w_in_run;
    logic             w_in_done;
    logic             w_cnt_zero;
    logic [CNT_W-1:0] w_load_val;
    logic [CNT_W-1:0] w_cnt;
    logic             w_hilo_en;

    assign w_in_run  = (r_state == ST_RUN);
    assign w_in_done = (r_state == ST_DONE);

    // A new op may start from IDLE or from DONE (back-to-back), never under a flush
    assign w_accept = start_i & ~flush_i & ((r_state == ST_IDLE) | w_in_done);

`ifdef MDU_DIV0_FAST_EN
    logic r_div0;

    // A divide by zero needs only one RUN cycle and must leave HI/LO untouched
    assign w_load_val = (op_i[1] & div0_i) ? '0 :
                        (op_i[1] ? c_div_load : c_mul_load);

    // Remember whether the running op is a fast divide-by-zero
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_div0 <= 1'b0;
        end else if (w_accept) begin
            r_div0 <= op_i[1] & div0_i;
        end
    end

    assign w_hilo_en = ~r_div0;
`else
    logic w_unused_div0;

    // Divide-by-zero runs the full length; the divisor flag has no effect here
    assign w_unused_div0 = div0_i;
    assign w_load_val    = op_i[1] ? c_div_load : c_mul_load;
    assign w_hilo_en     = 1'b1;
`endif

    mdu_cycle_counter #(
        .CNT_W      (CNT_W)
    ) u_cycle_counter (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_accept),
        .i_load_val (w_load_val),
        .i_dec      (w_in_run),
        .o_cnt      (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a flush in the first RUN cycle kills the younger op
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (flush_i && r_kill_ok) begin
                    w_next_state = ST_IDLE;
                end else if (w_cnt_zero) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = w_accept ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Op latch and kill window: only the first RUN cycle may be aborted by a flush
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_op      <= OP_MULT;
            r_kill_ok <= 1'b0;
        end else if (w_accept) begin
            r_op      <= op_i;
            r_kill_ok <= 1'b1;
        end else if (w_in_run) begin
            r_kill_ok <= 1'b0;
        end
    end

    assign mdu_load_o   = w_accept;
    assign mdu_step_o   = w_in_run;
    assign busy_o       = (r_state != ST_IDLE);
    assign done_o       = w_in_done;
    assign hilo_we_o    = w_in_done & w_hilo_en;
    // In the accept cycle the MDU loads operands, so it needs the incoming op type
    assign mdu_signed_o = w_accept ? ~op_i[0] : ~r_op[0];
    assign mdu_div_o    = w_accept ?  op_i[1] :  r_op[1];

    // No HI/LO forwarding: readers wait until the write has happened
    assign stall_o = ((w_accept | w_in_run) & (FD_HiLoRead_i | FD_MulDiv_i))
                   | (w_in_done & FD_HiLoRead_i);

endmodule : mdu_ctrl
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mdu_ctrl
//  Description : Self-checking bench for mdu_ctrl. Completion events are
//                queued when an op is issued and compared by a monitor when
//                done_o appears; cycle-level control outputs are checked
//                directly against hand-derived vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic       div0;
    logic       flush;
    logic       fd_hilo;
    logic       fd_muldiv;
    logic       mdu_load_o, mdu_step_o, mdu_signed_o, mdu_div_o;
    logic       busy_o, stall_o, hilo_we_o, done_o;

    always #5 clk = ~clk;

    mdu_ctrl #(
        .MUL_CYCLES    (4),
        .DIV_CYCLES    (32),
        .CNT_W         (6)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .start_i       (start),
        .op_i          (op),
        .div0_i        (div0),
        .flush_i       (flush),
        .FD_HiLoRead_i (fd_hilo),
        .FD_MulDiv_i   (fd_muldiv),
        .mdu_load_o    (mdu_load_o),
        .mdu_step_o    (mdu_step_o),
        .mdu_signed_o  (mdu_signed_o),
        .mdu_div_o     (mdu_div_o),
        .busy_o        (busy_o),
        .stall_o       (stall_o),
        .hilo_we_o     (hilo_we_o),
        .done_o        (done_o)
    );

    typedef struct {
        int   at_cyc;
        logic hilo;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   t;
    int   nbusy;
    logic sawstall;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every completion must match the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done_o) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: done_o at cycle %0d, none expected", cyc);
            end else begin
                e = sb.pop_front();
                if (e.at_cyc != cyc || e.hilo !== hilo_we_o) begin
                    errors++;
                    $display("FAIL done_event: got cycle=%0d hilo_we=%b, expected cycle=%0d hilo_we=%b",
                             cyc, hilo_we_o, e.at_cyc, e.hilo);
                end
            end
        end
        // A start must never be presented while the MDU is iterating
        if (rst_n && start) begin
            checks++;
            if (mdu_step_o) begin
                errors++;
                $display("FAIL start_in_run: start_i=1 while mdu_step_o=%b, expected 0", mdu_step_o);
            end
        end
    end

    // Vector order: {load, step, busy, stall, hilo_we, done}
    task automatic chk(input string name, input logic [5:0] exp);
        logic [5:0] got;
        got = {mdu_load_o, mdu_step_o, busy_o, stall_o, hilo_we_o, done_o};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got load/step/busy/stall/hilo/done=%b, expected %b", name, got, exp);
        end
    endtask

    task automatic chkn(input string name, input logic [5:0] exp);
        @(negedge clk);
        chk(name, exp);
    endtask

    task automatic chk_bit(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o) begin
            errors++;
            $display("FAIL idle_timeout: busy_o still %b after %0d cycles, expected 0", busy_o, budget);
        end
        next();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; op = OP_MULT; div0 = 1'b0;
        flush = 1'b0; fd_hilo = 1'b0; fd_muldiv = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", 6'b000000);
        chk_bit("reset_signed", mdu_signed_o, 1'b1);
        chk_bit("reset_div", mdu_div_o, 1'b0);
        #2 rst_n = 1'b1;
        next(); next();

        // MULT with an MFHI waiting in ID
        start = 1'b1; op = OP_MULT; fd_hilo = 1'b1; t = cyc;
        sb.push_back('{at_cyc: t + 5, hilo: 1'b1});
        chkn("mult_accept", 6'b100100);
        next(); start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chkn("mult_run", 6'b011100);
            next();
        end
        chkn("mult_done", 6'b001111);
        next();
        chkn("mult_after", 6'b000000);
        next(); fd_hilo = 1'b0;

        // DIVU with independent instructions in ID
        start = 1'b1; op = OP_DIVU; t = cyc;
        sb.push_back('{at_cyc: t + 33, hilo: 1'b1});
        chkn("divu_accept", 6'b100000);
        chk_bit("divu_signed", mdu_signed_o, 1'b0);
        chk_bit("divu_div", mdu_div_o, 1'b1);
        next(); start = 1'b0;
        nbusy = 0; sawstall = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_o) nbusy++;
            if (stall_o) sawstall = 1'b1;
            next();
        end
        chk_int("divu_busy_cycles", nbusy, 33);
        chk_bit("divu_no_stall", sawstall, 1'b0);

        // Back-to-back: DIV accepted in MULT's DONE cycle
        start = 1'b1; op = OP_MULT; t = cyc;
        sb.push_back('{at_cyc: t + 5, hilo: 1'b1});
        sb.push_back('{at_cyc: t + 38, hilo: 1'b1});
        chkn("b2b_mult_accept", 6'b100000);
        next(); start = 1'b0;
        repeat (4) begin
            chkn("b2b_mult_run", 6'b011000);
            next();
        end
        start = 1'b1; op = OP_DIV;
        chkn("b2b_done_load", 6'b101011);
        chk_bit("b2b_div_sel", mdu_div_o, 1'b1);
        chk_bit("b2b_div_signed", mdu_signed_o, 1'b1);
        next(); start = 1'b0;
        chkn("b2b_div_run", 6'b011000);
        wait_idle(40);

        // start together with flush is ignored
        start = 1'b1; flush = 1'b1; op = OP_MULT;
        chkn("start_flush", 6'b000000);
        next(); start = 1'b0; flush = 1'b0;
        chkn("start_flush_after", 6'b000000);
        next();

        // Flush in the first RUN cycle aborts the op
        start = 1'b1; op = OP_MULT;
        chkn("abort_accept", 6'b100000);
        next(); start = 1'b0; flush = 1'b1;
        chkn("abort_run1", 6'b011000);
        next(); flush = 1'b0;
        repeat (6) begin
            chkn("abort_quiet", 6'b000000);
            next();
        end

        // Flush in the second RUN cycle is ignored (MULTU)
        start = 1'b1; op = OP_MULTU; t = cyc;
        sb.push_back('{at_cyc: t + 5, hilo: 1'b1});
        chkn("multu_accept", 6'b100000);
        chk_bit("multu_signed", mdu_signed_o, 1'b0);
        next(); start = 1'b0;
        chkn("flush2_run1", 6'b011000);
        chk_bit("multu_signed_q", mdu_signed_o, 1'b0);
        next(); flush = 1'b1;
        chkn("flush2_run2", 6'b011000);
        next(); flush = 1'b0;
        wait_idle(10);

        // Asynchronous reset in RUN cycle 10 of a DIV
        start = 1'b1; op = OP_DIV; fd_muldiv = 1'b1;
        chkn("rst_div_accept", 6'b100100);
        next(); start = 1'b0;
        repeat (9) next();
        chk("rst_run10_pre", 6'b011100);
        rst_n = 1'b0;
        #1;
        chk("rst_run10_post", 6'b000000);
        @(negedge clk);
        #2 rst_n = 1'b1; fd_muldiv = 1'b0;
        next();
        start = 1'b1; op = OP_MULT; t = cyc;
        sb.push_back('{at_cyc: t + 5, hilo: 1'b1});
        chkn("rst_mult_accept", 6'b100000);
        next(); start = 1'b0;
        wait_idle(10);

        // Divide by zero
        start = 1'b1; op = OP_DIV; div0 = 1'b1; t = cyc;
`ifdef MDU_DIV0_FAST_EN
        sb.push_back('{at_cyc: t + 2, hilo: 1'b0});
`else
        sb.push_back('{at_cyc: t + 33, hilo: 1'b1});
`endif
        chkn("div0_accept", 6'b100000);
        next(); start = 1'b0; div0 = 1'b0;
        wait_idle(40);

        repeat (3) next();
        chk_int("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mdu_ctrl
`default_nettype wire

// File: doc/mdu_ctrl.md
# mdu_ctrl

Sequencer for the iterative multiply/divide unit (MDU) that sits beside the EX-stage ALU. It accepts MULT/MULTU/DIV/DIVU from ID/EX, counts the MDU through its fixed iteration count and pulses the HI/LO write. While it is running, it stalls any ID-stage instruction that reads HI/LO or issues another mult/div. Its stall output is ORed into the hazard unit's PC-hold, IF/ID-hold and ID/EX-bubble controls. Independent instructions keep flowing during an operation.

## Interface
- MUL_CYCLES, 4: RUN cycles for MULT/MULTU; 1 ≤ value < 2^CNT_W
- DIV_CYCLES, 32: RUN cycles for DIV/DIVU; 1 ≤ value < 2^CNT_W
- CNT_W, 6: iteration counter width
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  the ID/EX instruction is a mult/div
- op_i  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
- div0_i  in  1  divisor is zero; sampled with start_i
- flush_i  in  1  branch flush from the hazard unit
- FD_HiLoRead_i  in  1  the IF/ID instruction is MFHI/MFLO
- FD_MulDiv_i  in  1  the IF/ID instruction is a mult/div
- mdu_load_o  out  1  one-cycle pulse that loads operands into the MDU
- mdu_step_o  out  1  MDU performs one iteration this cycle
- mdu_signed_o  out  1  latched signedness (op_i[0]==0)
- mdu_div_o  out  1  latched divide select (op_i[1])
- busy_o  out  1  state is not IDLE
- stall_o  out  1  hold PC and IF/ID, bubble ID/EX
- hilo_we_o  out  1  write the MDU result to HI/LO
- done_o  out  1  operation completes this cycle

## Operation
- States: IDLE, RUN, DONE. Registers: cnt[CNT_W], op_q[2], kill_ok.
- accept = start_i & ~flush_i & (state==IDLE | state==DONE).
- On accept:
  - mdu_load_o=1.
  - op_q<=op_i.
  - cnt<=LAT-1, where LAT is MUL_CYCLES or DIV_CYCLES according to op_i[1].
  - kill_ok<=1.
  - state<=RUN.
- start_i with flush_i in the same cycle: ignored, no load pulse.
- start_i while in RUN: cannot occur, because stall_o blocks it. The bench asserts this.
- RUN:
  - mdu_step_o=1.
  - kill_ok<=0.
  - If cnt==0, go to DONE; otherwise cnt<=cnt-1.
- Abort: flush_i in RUN with kill_ok=1 (the first RUN cycle; the op is younger than the branch). Effects:
  - state<=IDLE.
  - No hilo_we_o or done_o.
  - mdu_step_o is still 1 in that cycle; harmless.
- DONE, one cycle:
  - hilo_we_o=1, done_o=1.
  - Next state is RUN on accept, otherwise IDLE.
- stall_o:
  - (accept | state==RUN) & (FD_HiLoRead_i | FD_MulDiv_i)
  - | (state==DONE & FD_HiLoRead_i)
- No HI/LO forwarding; MFHI/MFLO in ID during DONE is stalled one cycle.
- mdu_signed_o / mdu_div_o come from op_q, except in the accept cycle, where they come from op_i directly.

## Timing
- Reset values:
  - state=IDLE, cnt=0, op_q=0, kill_ok=0.
  - All outputs 0; mdu_signed_o=1, since op_q=00 (MULT).
- Latency, accept in cycle T:
  - RUN occupies T+1 .. T+LAT.
  - DONE (hilo_we_o) occurs in T+LAT+1.
- Throughput: back-to-back ops. A start accepted in DONE gives no IDLE gap.
- Reset mid-RUN: immediate IDLE, no HI/LO write, stall_o drops asynchronously.
- stall_o, mdu_load_o and hilo_we_o are combinational from state and inputs; there is no output register.

## Configuration
- MDU_DIV0_FAST_EN defined:
  - DIV/DIVU with div0_i=1 loads cnt<=0, so RUN lasts 1 cycle and DONE occurs in T+2.
  - hilo_we_o is suppressed in that DONE; HI/LO are left unchanged.
  - done_o is still 1.
- MDU_DIV0_FAST_EN undefined:
  - div0_i is ignored.
  - Divide-by-zero takes the full DIV_CYCLES and writes whatever the MDU produced.

## Structure
- mdu_pkg holds:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU)
  - state encodings (ST_IDLE, ST_RUN, ST_DONE)
  - default MUL_CYCLES/DIV_CYCLES
- Sub-module mdu_cycle_counter holds CNT_W-bit load/decrement logic with a zero flag. mdu_ctrl holds the FSM, op latch and stall logic.

## Test plan
- MULT accepted at T=0, FD_HiLoRead_i=1 held:
  - mdu_load_o at 0; mdu_step_o at 1..4.
  - hilo_we_o and done_o at 5.
  - stall_o high 0..5, low at 6.
- DIVU with FD_MulDiv_i=0, FD_HiLoRead_i=0: busy_o high for 33 cycles, stall_o never asserted, hilo_we_o at cycle 33.
- Back-to-back: DIV accepted during MULT's DONE cycle. Expect no IDLE cycle, mdu_load_o and hilo_we_o in the same cycle, and the DIV's DONE 33 cycles later.
- Flush interactions:
  - start_i+flush_i together: no load, busy_o stays 0.
  - flush_i in the first RUN cycle: return to IDLE, no hilo_we_o.
  - flush_i in the second RUN cycle: ignored, DONE as normal.
- rst_i low in RUN cycle 10 of DIV: all outputs 0 immediately; after release, a new MULT completes normally in 5 cycles.
- With MDU_DIV0_FAST_EN: DIV with div0_i=1 gives done_o at T+2 and hilo_we_o=0.
